// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshake, response and memory-port signals shared
// between the arbiter (slave) and the requesters/memory side (master).
interface mem_port_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_we;
    logic [32*NREQ-1:0]   req_addr;
    logic [32*NREQ-1:0]   req_wdata;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [32*NREQ-1:0]   rsp_rdata;
    logic [NREQ-1:0]      rsp_err;
    logic [31:0]          mem_addr1;
    logic [31:0]          mem_addr2;
    logic [7:0]           mem_data1_in  [0:3];
    logic [7:0]           mem_data2_in  [0:3];
    logic [7:0]           mem_data1_out [0:3];
    logic [7:0]           mem_data2_out [0:3];
    logic                 mem_we;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr1, mem_addr2, mem_data1_in, mem_data2_in, mem_we,
        output mem_data1_out, mem_data2_out
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr1, mem_addr2, mem_data1_in, mem_data2_in, mem_we,
        input  mem_data1_out, mem_data2_out
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing a dual-port byte memory (common write enable)
// among NREQ requesters; up to two compatible grants per cycle.
module mem_port_arbiter #(
    parameter int NREQ      = 3,
    parameter int MEM_BYTES = 256
) (
    input  logic              clk,
    input  logic              rst_b,
    mem_port_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]        ptr_q, ptr_d;
    logic [NREQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [NREQ-1:0]      rsp_err_q, rsp_err_d;
    logic [32*NREQ-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [NREQ-1:0]      in_range;
    logic [NREQ-1:0]      we_eff;
    logic [29:0]          wa_eff [NREQ];

    logic                 found_a, found_b;
    logic [PW-1:0]        idx_a, idx_b;
    logic [NREQ-1:0]      grant;
    logic                 mem_we_c;
    logic [31:0]          addr1_c, addr2_c;
    logic [7:0]           d1_c [0:3];
    logic [7:0]           d2_c [0:3];
    logic [31:0]          word1, word2;

    // Out-of-range requests become reads of word 0 so they can never write.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            in_range[i] = bus.req_addr[32*i +: 32] < 32'(MEM_BYTES);
            we_eff[i]   = bus.req_we[i] & in_range[i];
            wa_eff[i]   = in_range[i] ? bus.req_addr[32*i+2 +: 30] : '0;
        end
    end

    // Scan from ptr: first valid is A, first later valid compatible with A is B.
    always_comb begin
        int j;
        j       = 0;
        found_a = 1'b0;
        found_b = 1'b0;
        idx_a   = '0;
        idx_b   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_q) + k) % NREQ;
            if (bus.req_valid[j]) begin
                if (!found_a) begin
                    found_a = 1'b1;
                    idx_a   = PW'(j);
                end else if (!found_b &&
                             ((!we_eff[idx_a] && !we_eff[j]) || (wa_eff[idx_a] != wa_eff[j]))) begin
                    found_b = 1'b1;
                    idx_b   = PW'(j);
                end
            end
        end
    end

    // Grant vector (held off in reset) and pointer advance past the last grant.
    always_comb begin
        grant = '0;
        if (rst_b) begin
            if (found_a) grant[idx_a] = 1'b1;
            if (found_b) grant[idx_b] = 1'b1;
        end
        ptr_d = ptr_q;
        if (found_b)
            ptr_d = (int'(idx_b) == NREQ-1) ? '0 : idx_b + PW'(1);
        else if (found_a)
            ptr_d = (int'(idx_a) == NREQ-1) ? '0 : idx_a + PW'(1);
    end

    // Memory port drive; non-writing ports feed back their own read data so the
    // shared write enable rewrites unchanged bytes. Port 2 mirrors port 1 when idle.
    always_comb begin
        mem_we_c = rst_b && ((found_a && we_eff[idx_a]) || (found_b && we_eff[idx_b]));
        addr1_c  = found_a ? {wa_eff[idx_a], 2'b00} : '0;
        addr2_c  = found_b ? {wa_eff[idx_b], 2'b00} : addr1_c;
        for (int k = 0; k < 4; k++) begin
            d1_c[k] = (found_a && we_eff[idx_a]) ? bus.req_wdata[32*int'(idx_a) + 8*k +: 8]
                                                 : bus.mem_data1_out[k];
            if (found_b)
                d2_c[k] = we_eff[idx_b] ? bus.req_wdata[32*int'(idx_b) + 8*k +: 8]
                                        : bus.mem_data2_out[k];
            else
                d2_c[k] = d1_c[k];
        end
    end

    // Response capture: pre-write read word from the granted port, zero otherwise.
    always_comb begin
        word1 = {bus.mem_data1_out[3], bus.mem_data1_out[2], bus.mem_data1_out[1], bus.mem_data1_out[0]};
        word2 = {bus.mem_data2_out[3], bus.mem_data2_out[2], bus.mem_data2_out[1], bus.mem_data2_out[0]};
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid_d[i]        = grant[i];
            rsp_err_d[i]          = grant[i] & ~in_range[i];
            rsp_rdata_d[32*i +: 32] = '0;
            if (grant[i] && in_range[i] && !bus.req_we[i])
                rsp_rdata_d[32*i +: 32] = (found_a && int'(idx_a) == i) ? word1 : word2;
        end
    end

    // Pointer and response registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ptr_q       <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            rsp_rdata_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Output mapping.
    always_comb begin
        bus.req_ready = grant;
        bus.rsp_valid = rsp_valid_q;
        bus.rsp_err   = rsp_err_q;
        bus.rsp_rdata = rsp_rdata_q;
        bus.mem_we    = mem_we_c;
        bus.mem_addr1 = addr1_c;
        bus.mem_addr2 = addr2_c;
        for (int k = 0; k < 4; k++) begin
            bus.mem_data1_in[k] = d1_c[k];
            bus.mem_data2_in[k] = d2_c[k];
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the dual-port, word-aligned byte memory (256 bytes, combinational read, synchronous write with a single write enable common to both ports) among NREQ requesters. Each cycle it grants up to two compatible requests, one per memory port, in round-robin order. It drives the memory ports so that the shared write enable never corrupts a word on the other port. Read data and write acks return one cycle after the grant.

## Interface
Parameters:
- NREQ, 3, number of requesters (2..8)
- MEM_BYTES, 256, memory size in bytes; must match the memory instance

Ports (per-requester vectors are flat; slice i is bits [W*i+W-1 : W*i]; byte lane k of any 32-bit data is bits [8k+7:8k] and maps to array element [k]):
- clk  in  1  clock, all state on rising edge
- rst_b  in  1  asynchronous active-low reset
- req_valid  in  NREQ  request pending
- req_we  in  NREQ  1 = write, 0 = read
- req_addr  in  32*NREQ  byte address; bits [1:0] ignored
- req_wdata  in  32*NREQ  write data
- req_ready  out  NREQ  grant; a transfer occurs when valid & ready
- rsp_valid  out  NREQ  one-cycle response pulse
- rsp_rdata  out  32*NREQ  read data (0 for writes and errors)
- rsp_err  out  NREQ  address out of range
- mem_addr1, mem_addr2  out  32  memory port addresses
- mem_data1_in, mem_data2_in  out  8 x [0:3]  memory write data
- mem_data1_out, mem_data2_out  in  8 x [0:3]  memory read data
- mem_we  out  1  memory write enable

## Operation
- Word address: wa = addr[31:2]. A request is out of range if addr >= MEM_BYTES. It is then treated as a read of wa 0 for compatibility and porting, and returns rsp_err=1 and rdata=0. It never writes.
- Round-robin pointer ptr (0..NREQ-1). Scan requesters ptr, ptr+1, … modulo NREQ. The first valid one is A and goes to port 1. Continue the scan for the first valid B compatible with A; B goes to port 2.
- Compatibility: two reads are always compatible, including to the same word. If either is a write, A and B are compatible only if wa differs. Incompatible requesters are skipped this cycle.
- ptr update: (index of last requester granted in scan order + 1) mod NREQ. Unchanged when nothing is granted.
- Port drive:
  - Only A granted: port 2 mirrors port 1 in address and data.
  - No grant: addresses 0, mem_we=0.
- mem_we = 1 iff a granted, in-range write exists.
  - Write port: data_in = req_wdata.
  - Read or error port while mem_we=1: data_in = that port's data_out, so the shared enable rewrites the unchanged value. The compatibility rule guarantees this never aliases a written word.
- req_ready[i] is combinational from the same-cycle valid vector and ptr. A requester holds valid, we, addr and wdata stable until ready.
- Responses are registered at the grant edge:
  - rsp_valid[i] pulses in the next cycle.
  - rsp_rdata[i] carries the pre-write word, assembled from the data_out bytes of the granted port.
  - rsp_err[i] is set for out-of-range requests.
- Outputs with no response: rsp_valid=0, rsp_rdata=0, rsp_err=0.

## Timing
- Reset (async assert) clears ptr, rsp_valid, rsp_rdata and rsp_err to 0. req_ready is forced 0 and mem_we is forced 0 while rst_b is low. The memory also clears.
- Reset mid-operation drops any pending response pulse. No grant is issued until the first edge after deassertion.
- Latency: a grant at edge N produces rsp_valid high during cycle N+1.
- A write granted at N is visible to any read granted at N+1 or later.
- A requester re-asserting valid during its rsp_valid cycle may be granted in that same cycle (back-to-back throughput of 1 per requester per cycle, subject to arbitration).
- Maximum two grants per cycle. A single requester is never granted both ports.

## Test plan
- Reset: assert rst_b=0 with all req_valid=1 -> req_ready=0, mem_we=0, rsp_valid=0. Release -> first grants go to req0 (port 1) and req1 (port 2).
- Three reads (0x00, 0x04, 0x08), ptr=0 -> cycle 0 grants req0 and req1, ptr becomes 2. Cycle 1 grants req2, ptr becomes 0. Each rsp_valid pulses one cycle after its own grant with the correct words.
- req0 writes 0x10 with 0xDDCCBBAA and req1 reads 0x13, same cycle -> only req0 granted. req1 is granted next cycle and returns 0xDDCCBBAA (mem[0x10]=0xAA).
- req1 writes 0x40 with 0x11223344 and req2 reads 0x44 (preloaded 0x55667788), both granted, mem_we=1 -> 0x40 word updated, 0x44 word still 0x55667788, req2 rdata 0x55667788.
- req0 writes 0x20 with 0x1 and req1 writes 0x23 with 0x2 -> serialized over two cycles. Final word at 0x20 is 0x2, and each requester gets one ack.
- req0 writes 0x100 with 0xFFFFFFFF -> granted, mem_we=0, rsp_err=1, rdata=0. Words 0x00 and 0xFC are unchanged.
